// File: rtl/max7219_seq.sv
// max7219_seq: programs the MAX7219 control registers after reset, then
// rewrites the digit registers from a snapshot of the clock's BCD value,
// one 12-bit write at a time over the driver's strobe/busy/ack handshake.
module max7219_seq #(
  parameter int NUM_DIGITS = 8,
  parameter int TIMEOUT    = 31
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_digits,
  input  logic [7:0]  i_dp,
  input  logic [3:0]  i_intensity,
  input  logic        i_refresh,
  input  logic        i_reinit,
  output logic        o_drv_stb,
  output logic [3:0]  o_drv_addr,
  output logic [7:0]  o_drv_data,
  input  logic        i_drv_busy,
  input  logic        i_drv_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

  // Write selector: 0..4 are the init list, 5 is a refresh-time intensity
  // update, 8..15 are digit registers (bit 3 marks a digit write).
  localparam logic [3:0] SEL_TEST = 4'd0;
  localparam logic [3:0] SEL_SHUT = 4'd4;
  localparam logic [3:0] SEL_INT  = 4'd5;
  localparam logic [3:0] SEL_DIG0 = 4'd8;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ACK, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boot_q, boot_d;
  logic             pend_ref_q, pend_ref_d;
  logic             pend_init_q, pend_init_d;
  logic [3:0]       int_last_q, int_last_d;
  logic [31:0]      snap_dig_q, snap_dig_d;
  logic [7:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       snap_int_q, snap_int_d;
  logic             stb_q, stb_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  function automatic logic [3:0] wr_addr(input logic [3:0] sel);
    case (sel)
      4'd0:       wr_addr = 4'hF;
      4'd1:       wr_addr = 4'hB;
      4'd2:       wr_addr = 4'h9;
      4'd3, 4'd5: wr_addr = 4'hA;
      4'd4:       wr_addr = 4'hC;
      default:    wr_addr = {1'b0, sel[2:0]} + 4'd1;
    endcase
  endfunction

  function automatic logic [7:0] wr_data(input logic [3:0]  sel,
                                         input logic [31:0] digits,
                                         input logic [7:0]  dp,
                                         input logic [3:0]  inten);
    case (sel)
      4'd0:       wr_data = 8'h00;
      4'd1:       wr_data = 8'(NUM_DIGITS - 1);
      4'd2:       wr_data = 8'hFF;
      4'd3, 4'd5: wr_data = {4'h0, inten};
      4'd4:       wr_data = 8'h01;
      default:    wr_data = {dp[sel[2:0]], 3'b000, digits[{sel[2:0], 2'b00} +: 4]};
    endcase
  endfunction

  // Next-state, request capture and output register values
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    boot_d      = boot_q;
    pend_ref_d  = pend_ref_q;
    pend_init_d = pend_init_q;
    int_last_d  = int_last_q;
    snap_dig_d  = snap_dig_q;
    snap_dp_d   = snap_dp_q;
    snap_int_d  = snap_int_q;
    stb_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;

    if (state_q != S_IDLE) begin
      if (i_refresh) pend_ref_d  = 1'b1;
      if (i_reinit)  pend_init_d = 1'b1;
    end
    if (i_reinit) error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Snapshot tracks the inputs until a sequence leaves IDLE.
        snap_dig_d = i_digits;
        snap_dp_d  = i_dp;
        snap_int_d = i_intensity;
        if (boot_q || pend_init_q || i_reinit) begin
          state_d     = S_LOAD;
          sel_d       = SEL_TEST;
          busy_d      = 1'b1;
          boot_d      = 1'b0;
          pend_init_d = 1'b0;
          pend_ref_d  = 1'b0;
        end else if (pend_ref_q || i_refresh) begin
          state_d    = S_LOAD;
          sel_d      = (i_intensity != int_last_q) ? SEL_INT : SEL_DIG0;
          busy_d     = 1'b1;
          pend_ref_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (!i_drv_busy) begin
          state_d = S_ISSUE;
          stb_d   = 1'b1;
          addr_d  = wr_addr(sel_q);
          data_d  = wr_data(sel_q, snap_dig_q, snap_dp_q, snap_int_q);
          if (sel_q == 4'd3 || sel_q == SEL_INT) int_last_d = snap_int_q;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
        cnt_d   = '0;
      end
      S_WAIT_ACK: begin
        if (i_drv_ack) begin
          if (sel_q == SEL_SHUT) begin
            // Init chains straight into its refresh, which absorbs any
            // refresh request that was waiting.
            state_d    = S_LOAD;
            sel_d      = (snap_int_q != int_last_q) ? SEL_INT : SEL_DIG0;
            pend_ref_d = 1'b0;
          end else if (sel_q[3] && sel_q[2:0] == LAST_DIG) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_LOAD;
            sel_d   = (sel_q == SEL_INT) ? SEL_DIG0 : sel_q + 4'd1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          error_d     = 1'b1;
          busy_d      = 1'b0;
          pend_ref_d  = 1'b0;
          pend_init_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and output registers; the snapshot is plain data and is not reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      sel_q       <= SEL_TEST;
      cnt_q       <= '0;
      boot_q      <= 1'b1;
      pend_ref_q  <= 1'b0;
      pend_init_q <= 1'b0;
      int_last_q  <= 4'h0;
      stb_q       <= 1'b0;
      addr_q      <= 4'h0;
      data_q      <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      boot_q      <= boot_d;
      pend_ref_q  <= pend_ref_d;
      pend_init_q <= pend_init_d;
      int_last_q  <= int_last_d;
      stb_q       <= stb_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
    snap_dig_q <= snap_dig_d;
    snap_dp_q  <= snap_dp_d;
    snap_int_q <= snap_int_d;
  end

  assign o_drv_stb  = stb_q;
  assign o_drv_addr = addr_q;
  assign o_drv_data = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_max7219_seq.sv
// tb_max7219_seq: directed bench for max7219_seq with a driver model that
// acks 17 cycles after each strobe.
module tb_max7219_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits = 32'h87654321;
  logic [7:0]  dp = 8'h00;
  logic [3:0]  inten = 4'h0;
  logic        refresh = 1'b0;
  logic        reinit = 1'b0;
  logic        drv_busy = 1'b0;
  logic        drv_ack = 1'b0;
  logic        stb;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic        busy;
  logic        done;
  logic        error;

  max7219_seq #(.NUM_DIGITS(8), .TIMEOUT(31)) dut (
    .i_clk(clk), .i_reset(rst), .i_digits(digits), .i_dp(dp),
    .i_intensity(inten), .i_refresh(refresh), .i_reinit(reinit),
    .o_drv_stb(stb), .o_drv_addr(addr), .o_drv_data(data),
    .i_drv_busy(drv_busy), .i_drv_ack(drv_ack),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          nlog = 0;
  int          done_cnt = 0;
  int          ack_cd = 0;
  logic        ack_en = 1'b1;
  logic [11:0] log_w [64];
  int          log_cyc [64];
  logic [11:0] exp_q [$];

  // Driver model and strobe/done monitor, evaluated just after each edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack_cd > 0) begin
        ack_cd--;
        drv_ack = (ack_cd == 0) && ack_en;
      end else begin
        drv_ack = 1'b0;
      end
      if (stb) begin
        if (nlog < 64) begin
          log_w[nlog]   = {addr, data};
          log_cyc[nlog] = cyc;
        end
        nlog++;
        ack_cd = 17;
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, nlog, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < 64; i++)
      chk($sformatf("%s[%0d]", tag, i), {20'h0, log_w[i]}, {20'h0, exp_q[i]});
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && nlog < n; i++) @(negedge clk);
    chk(tag, (nlog >= n), 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
    chk(tag, (done_cnt >= n), 1);
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    nlog = 0;
    done_cnt = 0;
  endtask

  initial begin
    int c;
    int bad;

    // Reset values
    idle(3);
    chk("rst_stb", stb, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);

    // Auto init after reset release, chained into a refresh
    clear_log();
    rst = 1'b0;
    wait_done(1, 400, "init_done_timeout");
    chk("init_busy_at_done", busy, 0);
    exp_q = {12'hF00, 12'hB07, 12'h9FF, 12'hA00, 12'hC01,
             12'h101, 12'h202, 12'h303, 12'h404, 12'h505, 12'h606, 12'h707, 12'h808};
    check_log("init");
    bad = 0;
    for (int i = 0; i < 12; i++) if (log_cyc[i+1] - log_cyc[i] != 19) bad++;
    chk("init_gap19", bad, 0);
    idle(30);
    chk("init_done_once", done_cnt, 1);

    // Plain refresh with decimal point on digit 0; mid-frame input change
    dp = 8'h01;
    clear_log();
    c = cyc;
    pulse_refresh();
    wait_log(1, 10, "ref_first_timeout");
    chk("ref_latency", log_cyc[0], c + 2);
    wait_log(2, 40, "ref_second_timeout");
    digits = 32'hFFFFFFFF;
    dp = 8'hFF;
    wait_done(1, 200, "ref_done_timeout");
    exp_q = {12'h181, 12'h202, 12'h303, 12'h404, 12'h505, 12'h606, 12'h707, 12'h808};
    check_log("ref");

    // Intensity change is written ahead of digit 1
    digits = 32'h12345678;
    dp = 8'h80;
    inten = 4'h9;
    idle(2);
    clear_log();
    pulse_refresh();
    wait_done(1, 250, "int_done_timeout");
    exp_q = {12'hA09, 12'h108, 12'h207, 12'h306, 12'h405, 12'h504, 12'h603, 12'h702, 12'h881};
    check_log("int");

    // Merged requests during a refresh: one init+refresh follows
    idle(2);
    clear_log();
    pulse_refresh();
    idle(10);
    pulse_refresh();
    idle(20);
    pulse_refresh();
    pulse_reinit();
    idle(5);
    pulse_refresh();
    wait_done(2, 800, "merge_done_timeout");
    idle(80);
    chk("merge_done_twice", done_cnt, 2);
    chk("merge_busy_low", busy, 0);
    exp_q = {12'h108, 12'h207, 12'h306, 12'h405, 12'h504, 12'h603, 12'h702, 12'h881,
             12'hF00, 12'hB07, 12'h9FF, 12'hA09, 12'hC01,
             12'h108, 12'h207, 12'h306, 12'h405, 12'h504, 12'h603, 12'h702, 12'h881};
    check_log("merge");

    // Ack timeout sets the sticky error; reinit clears it and restarts
    ack_en = 1'b0;
    clear_log();
    pulse_refresh();
    wait_log(1, 10, "to_strobe_timeout");
    c = log_cyc[0];
    for (int i = 0; i < 60 && cyc < c + 31; i++) @(negedge clk);
    chk("to_err_before", error, 0);
    chk("to_busy_before", busy, 1);
    @(negedge clk);
    chk("to_err_set", error, 1);
    chk("to_busy_clr", busy, 0);
    idle(20);
    chk("to_no_done", done_cnt, 0);
    chk("to_no_more_strobes", nlog, 1);
    chk("to_err_sticky", error, 1);
    ack_en = 1'b1;
    clear_log();
    pulse_reinit();
    chk("to_err_cleared", error, 0);
    wait_done(1, 400, "to_reinit_done_timeout");
    chk("to_reinit_count", nlog, 13);
    chk("to_reinit_first", {20'h0, log_w[0]}, 32'hF00);
    chk("to_reinit_int", {20'h0, log_w[3]}, 32'hA09);

    // Driver busy blocks the strobe
    idle(3);
    clear_log();
    drv_busy = 1'b1;
    pulse_refresh();
    idle(40);
    chk("dbusy_no_strobe", nlog, 0);
    chk("dbusy_seq_busy", busy, 1);
    c = cyc;
    drv_busy = 1'b0;
    wait_log(1, 10, "dbusy_strobe_timeout");
    chk("dbusy_release_latency", log_cyc[0], c + 1);

    // Reset in the middle of a refresh, during a strobe cycle
    wait_log(3, 80, "mid_strobe_timeout");
    chk("mid_stb_seen", stb, 1);
    rst = 1'b1;
    ack_cd = 0;
    drv_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_stb", stb, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_error", error, 0);
    idle(3);
    clear_log();
    rst = 1'b0;
    wait_done(1, 400, "mid_reinit_done_timeout");
    exp_q = {12'hF00, 12'hB07, 12'h9FF, 12'hA09, 12'hC01,
             12'h108, 12'h207, 12'h306, 12'h405, 12'h504, 12'h603, 12'h702, 12'h881};
    check_log("mid_init");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/max7219_seq.md
# max7219_seq

Sequencer for the MAX7219 SPI write driver. After reset it programs the chip's control registers (display test, scan limit, decode mode, intensity, shutdown), then refreshes the digit registers from a coherent snapshot of the clock's BCD display value. It issues one 12-bit address/data write at a time to the driver over the driver's strobe/busy/ack handshake. It sits between the clock display logic and the `max7219` instance.

## Interface
- `NUM_DIGITS`, default 8: digits driven, legal range 1..8; scan-limit value written is `NUM_DIGITS-1`.
- `TIMEOUT`, default 31: maximum cycles to wait for driver ack after a strobe before declaring an error.
- `i_clk`, in, 1: system clock, single clock domain.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_digits`, in, 32: BCD nibbles; digit n (0-based) is `i_digits[4n+3:4n]`.
- `i_dp`, in, 8: decimal point per digit; bit n maps to digit n.
- `i_intensity`, in, 4: brightness code for register 0xA.
- `i_refresh`, in, 1: one-cycle request to rewrite all digit registers.
- `i_reinit`, in, 1: one-cycle request to rerun the full init sequence, followed by a refresh.
- `o_drv_stb`, out, 1: write strobe to the driver; one-cycle pulse.
- `o_drv_addr`, out, 4: register address to the driver.
- `o_drv_data`, out, 8: register data to the driver.
- `i_drv_busy`, in, 1: driver busy.
- `i_drv_ack`, in, 1: driver write-complete pulse.
- `o_busy`, out, 1: high while an init or refresh sequence is in progress.
- `o_done`, out, 1: one-cycle pulse when a sequence completes.
- `o_error`, out, 1: sticky flag for ack timeout; cleared by `i_reset` or `i_reinit`.

## Operation
- States:
  - IDLE
  - LOAD: select the next write.
  - ISSUE: `o_drv_stb`=1 for exactly one cycle.
  - WAIT_ACK
  - FINISH
- ISSUE is entered only when `i_drv_busy`=0. If the driver is busy, the FSM holds in LOAD with the strobe low.
- Init write list, in order:
  - 0xF←0x00 (test off)
  - 0xB←`NUM_DIGITS-1`
  - 0x9←0xFF (code-B decode all digits)
  - 0xA←{4'h0, `i_intensity`}
  - 0xC←0x01 (normal operation)
- Refresh write list: digit register `n+1` ← {`i_dp[n]`, 3'b000, `i_digits[4n+3:4n]`}, for n = 0..`NUM_DIGITS-1`, ascending.
- Snapshot: `i_digits`, `i_dp` and `i_intensity` are registered on the cycle a sequence leaves IDLE. Input changes during a sequence do not affect it.
- Intensity tracking: the last written intensity is stored. If the snapshot differs from it at refresh start, 0xA is written before digit 1.
- Auto start: the first cycle after `i_reset` deasserts starts init, then chains straight into refresh without returning to IDLE.
- Request pending bits:
  - `i_refresh` or `i_reinit` arriving while busy sets a pending bit; one deep, repeats are merged.
  - Pending requests are serviced from IDLE on the cycle after FINISH.
  - Reinit has priority over refresh. A reinit always ends with a refresh, which clears any pending refresh.
  - A request arriving in IDLE starts the next cycle.
- Timeout:
  - A counter runs in WAIT_ACK. If `TIMEOUT` cycles elapse without `i_drv_ack`, `o_error`←1 and the FSM goes to IDLE.
  - On timeout, pending bits clear and `o_done` does not pulse.
- Ack outside WAIT_ACK is ignored.

## Timing
- Reset values: all of the following are 0.
  - Driver outputs: `o_drv_stb`, `o_drv_addr`, `o_drv_data`.
  - Status outputs: `o_busy`, `o_done`, `o_error`.
  - Internal state: pending bits; stored intensity = 0.
- `i_reset` mid-sequence: the strobe drops on the next edge, the sequence is abandoned, and the auto init reruns after release. The driver is reset from the same source.
- `o_busy` rises the cycle after a sequence start is accepted and falls in the same cycle `o_done` pulses.
- Write cadence against the driver (ack 17 cycles after the strobe edge):
  - Strobe at cycle t, ack sampled at t+17, LOAD at t+18, next strobe at t+19.
  - Each write therefore takes 19 cycles.
- `o_drv_addr` and `o_drv_data` are valid in the strobe cycle and held until the next LOAD.
- `o_done` pulses the cycle after the final ack (FINISH).
- Request to first strobe: 2 cycles from IDLE.

## Test plan
- Reset release, driver model acks 17 cycles after each strobe -> strobes in order (F,00), (B,07), (9,FF), (A,0i), (C,01), then digits 1..8. `o_done` once, 13 writes, 19 cycles between strobes.
- `i_digits`=0x87654321, `i_dp`=0x01, `i_refresh` in IDLE -> data 0x81, 0x02, 0x03 … 0x08 to addresses 1..8. No 0xA write. Changing `i_digits` mid-frame does not alter the frame.
- Change `i_intensity` 0→9, then `i_refresh` -> first write is (A,09), then 8 digit writes.
- `i_refresh` pulsed 3 times and `i_reinit` once during a refresh -> exactly one init+refresh follows, and `o_done` pulses exactly twice in total.
- Driver never acks -> `o_error`=1 after 31 WAIT_ACK cycles, `o_busy`=0, no `o_done`. `i_reinit` clears `o_error` and restarts init.
- `i_drv_busy` held high for 40 cycles, then a request -> no strobe while busy. Assert `i_reset` mid-refresh -> strobe 0 next cycle, outputs at reset values, init reruns on release.
